// File: rtl/tinymips_bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// tinymips_pkg
// Shared constants for the TinyMIPS bus responder.
//   - MMIO_BASE_DEFAULT : first word address of the register bank
//   - OFF_*             : register offsets inside the 16-word bank
//   - CTRL_* / STATUS_* : bit positions inside CTRL and STATUS
//   - word_t            : 16-bit bus word
// -----------------------------------------------------------------------------
package tinymips_pkg;

    typedef logic [15:0] word_t;

    localparam logic [7:0] MMIO_BASE_DEFAULT = 8'hF0;

    // Register offsets from MMIO_BASE
    localparam logic [3:0] OFF_CTRL    = 4'd0;
    localparam logic [3:0] OFF_CNT     = 4'd1;
    localparam logic [3:0] OFF_CMP     = 4'd2;
    localparam logic [3:0] OFF_STATUS  = 4'd3;
    localparam logic [3:0] OFF_LED     = 4'd4;
    localparam logic [3:0] OFF_SCRATCH = 4'd5;
    localparam logic [3:0] OFF_CYC_LO  = 4'd6;
    localparam logic [3:0] OFF_CYC_HI  = 4'd7;

    // Offsets 0..N_WR_OFFSETS-1 are the ones that accept CPU writes
    localparam int N_WR_OFFSETS = 6;

    // CTRL bit indices
    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_BITS       = 2;

    // STATUS bit indices
    localparam int STATUS_MATCH = 0;

    // CTRL as seen on the bus: implemented bits, everything else reads 0
    function automatic word_t ctrl_to_word(input logic [CTRL_BITS-1:0] ctrl);
        return {{(16 - CTRL_BITS){1'b0}}, ctrl};
    endfunction

    // STATUS as seen on the bus
    function automatic word_t status_to_word(input logic match);
        word_t w;
        w = '0;
        w[STATUS_MATCH] = match;
        return w;
    endfunction

endpackage

// File: rtl/tinymips_bus_responder_mmio_timer.sv
// -----------------------------------------------------------------------------
// mmio_timer
// 16-bit compare timer living in the responder's register bank.
// Holds CTRL, CNT, CMP and STATUS and produces the level interrupt.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous active-low reset
//   i_wr_ctrl    : CPU write strobe for CTRL this cycle
//   i_wr_cnt     : CPU write strobe for CNT this cycle
//   i_wr_cmp     : CPU write strobe for CMP this cycle
//   i_wr_status  : CPU write strobe for STATUS this cycle (write-1-to-clear)
//   i_wdata      : CPU write data
//   o_ctrl       : current CTRL bits {AUTORELOAD, EN}
//   o_cnt        : current counter value
//   o_cmp        : current compare value
//   o_match      : STATUS.MATCH (sticky)
//   o_irq        : level copy of STATUS.MATCH
// -----------------------------------------------------------------------------
module mmio_timer
    import tinymips_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_ctrl,
    input  logic                 i_wr_cnt,
    input  logic                 i_wr_cmp,
    input  logic                 i_wr_status,
    input  logic [15:0]          i_wdata,
    output logic [CTRL_BITS-1:0] o_ctrl,
    output logic [15:0]          o_cnt,
    output logic [15:0]          o_cmp,
    output logic                 o_match,
    output logic                 o_irq
);

    logic [CTRL_BITS-1:0] r_ctrl;
    logic [CTRL_BITS-1:0] r_ctrl_next;
    logic [15:0]          r_cnt;
    logic [15:0]          r_cnt_next;
    logic [15:0]          r_cmp;
    logic [15:0]          r_cmp_next;
    logic                 r_match;
    logic                 r_match_next;

    logic                 w_en;
    logic                 w_autoreload;
    logic                 w_hit;

    // The registered CTRL is what governs this cycle, so a CTRL write only
    // changes behaviour from the following cycle.
    assign w_en         = r_ctrl[CTRL_EN];
    assign w_autoreload = r_ctrl[CTRL_AUTORELOAD];
    assign w_hit        = w_en && (r_cnt == r_cmp);

    always_comb begin
        r_ctrl_next = r_ctrl;
        if (i_wr_ctrl) begin
            r_ctrl_next = i_wdata[CTRL_BITS-1:0];
        end
    end

    always_comb begin
        r_cmp_next = r_cmp;
        if (i_wr_cmp) begin
            r_cmp_next = i_wdata;
        end
    end

    // CPU write beats the running increment; the +1 wraps naturally mod 2^16.
    always_comb begin
        r_cnt_next = r_cnt;
        if (i_wr_cnt) begin
            r_cnt_next = i_wdata;
        end else if (w_en) begin
            if (w_hit && w_autoreload) begin
                r_cnt_next = 16'h0000;
            end else begin
                r_cnt_next = r_cnt + 16'h0001;
            end
        end
    end

    // A fresh match outranks a simultaneous write-1-to-clear.
    always_comb begin
        r_match_next = r_match;
        if (w_hit) begin
            r_match_next = 1'b1;
        end else if (i_wr_status && i_wdata[STATUS_MATCH]) begin
            r_match_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl  <= '0;
            r_cnt   <= 16'h0000;
            r_cmp   <= 16'h0000;
            r_match <= 1'b0;
        end else begin
            r_ctrl  <= r_ctrl_next;
            r_cnt   <= r_cnt_next;
            r_cmp   <= r_cmp_next;
            r_match <= r_match_next;
        end
    end

    assign o_ctrl  = r_ctrl;
    assign o_cnt   = r_cnt;
    assign o_cmp   = r_cmp;
    assign o_match = r_match;
    assign o_irq   = r_match;

endmodule

// File: rtl/tinymips_bus_responder.sv
// -----------------------------------------------------------------------------
// tinymips_bus_responder
// Memory-side responder between the TinyMIPS core and blram. Word addresses
// below MMIO_BASE go to the block RAM; MMIO_BASE..MMIO_BASE+15 are served by an
// internal register bank (timer, LED, scratch, cycle counter). Read data is
// returned one cycle after the address, matching blram's latency.
//
// Ports
//   clk       : clock
//   rst       : asynchronous active-low reset
//   cpu_we    : write strobe from the core
//   cpu_addr  : word address from the core
//   cpu_din   : write data from the core
//   cpu_dout  : read data to the core (one cycle after the address)
//   ram_we    : write strobe to blram (never set for bank addresses)
//   ram_addr  : address to blram (mirrors cpu_addr)
//   ram_din   : write data to blram (mirrors cpu_din)
//   ram_dout  : blram registered read data
//   led       : LED register contents
//   timer_irq : level timer interrupt (STATUS.MATCH)
// -----------------------------------------------------------------------------
module tinymips_bus_responder
    import tinymips_pkg::*;
#(
    parameter int              SIZE      = 8,
    parameter logic [SIZE-1:0] MMIO_BASE = SIZE'(MMIO_BASE_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_we,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [15:0]     cpu_din,
    output logic [15:0]     cpu_dout,
    output logic            ram_we,
    output logic [SIZE-1:0] ram_addr,
    output logic [15:0]     ram_din,
    input  logic [15:0]     ram_dout,
    output logic [15:0]     led,
    output logic            timer_irq
);

    localparam logic [SIZE-1:0] BANK_SPAN = SIZE'(16);

    // ---------------------------------------------------------------- decode
    logic                    w_is_mmio;
    logic [SIZE-1:0]         w_off_full;
    logic                    w_in_bank;
    logic [3:0]              w_off;
    logic                    w_bank_we;
    logic                    w_bank_rd;
    logic [N_WR_OFFSETS-1:0] w_wr_sel;
    logic                    w_rd_cyc_lo;

    // Everything at or above the base is claimed by the responder. Only the
    // first 16 words of that range hold registers; the rest reads as 0.
    assign w_is_mmio  = (cpu_addr >= MMIO_BASE);
    assign w_off_full = cpu_addr - MMIO_BASE;
    assign w_in_bank  = w_is_mmio && (w_off_full < BANK_SPAN);
    assign w_off      = w_off_full[3:0];
    assign w_bank_we  = cpu_we && w_in_bank;
    assign w_bank_rd  = !cpu_we && w_in_bank;

    genvar gi;
    generate
        for (gi = 0; gi < N_WR_OFFSETS; gi++) begin : g_wr_dec
            assign w_wr_sel[gi] = w_bank_we && (w_off == 4'(gi));
        end
    endgenerate

    assign w_rd_cyc_lo = w_bank_rd && (w_off == OFF_CYC_LO);

    // ---------------------------------------------------------- RAM passthru
    assign ram_addr = cpu_addr;
    assign ram_din  = cpu_din;
    assign ram_we   = cpu_we && !w_is_mmio;

    // ----------------------------------------------------------------- timer
    logic [CTRL_BITS-1:0] w_tmr_ctrl;
    logic [15:0]          w_tmr_cnt;
    logic [15:0]          w_tmr_cmp;
    logic                 w_tmr_match;
    logic                 w_tmr_irq;

    mmio_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_wr_ctrl   (w_wr_sel[OFF_CTRL]),
        .i_wr_cnt    (w_wr_sel[OFF_CNT]),
        .i_wr_cmp    (w_wr_sel[OFF_CMP]),
        .i_wr_status (w_wr_sel[OFF_STATUS]),
        .i_wdata     (cpu_din),
        .o_ctrl      (w_tmr_ctrl),
        .o_cnt       (w_tmr_cnt),
        .o_cmp       (w_tmr_cmp),
        .o_match     (w_tmr_match),
        .o_irq       (w_tmr_irq)
    );

    assign timer_irq = w_tmr_irq;

    // ------------------------------------------------------ local registers
    logic [15:0] r_led;
    logic [15:0] r_led_next;
    logic [15:0] r_scratch;
    logic [15:0] r_scratch_next;
    logic [31:0] r_cyc;
    logic [15:0] r_cyc_hi_snap;
    logic [15:0] r_cyc_hi_snap_next;
    logic        r_sel;
    logic [15:0] r_rdata;
    logic [15:0] w_rdata;

    always_comb begin
        r_led_next = r_led;
        if (w_wr_sel[OFF_LED]) begin
            r_led_next = cpu_din;
        end
    end

    always_comb begin
        r_scratch_next = r_scratch;
        if (w_wr_sel[OFF_SCRATCH]) begin
            r_scratch_next = cpu_din;
        end
    end

    // Reading the low half freezes the high half of the same count, so a
    // LO-then-HI pair is coherent even across a carry into bit 16.
    always_comb begin
        r_cyc_hi_snap_next = r_cyc_hi_snap;
        if (w_rd_cyc_lo) begin
            r_cyc_hi_snap_next = r_cyc[31:16];
        end
    end

    // --------------------------------------------------------------- read mux
    always_comb begin
        w_rdata = 16'h0000;
        if (w_in_bank) begin
            case (w_off)
                OFF_CTRL:    w_rdata = ctrl_to_word(w_tmr_ctrl);
                OFF_CNT:     w_rdata = w_tmr_cnt;
                OFF_CMP:     w_rdata = w_tmr_cmp;
                OFF_STATUS:  w_rdata = status_to_word(w_tmr_match);
                OFF_LED:     w_rdata = r_led;
                OFF_SCRATCH: w_rdata = r_scratch;
                OFF_CYC_LO:  w_rdata = r_cyc[15:0];
                OFF_CYC_HI:  w_rdata = r_cyc_hi_snap;
                default:     w_rdata = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led         <= 16'h0000;
            r_scratch     <= 16'h0000;
            r_cyc         <= 32'h0000_0000;
            r_cyc_hi_snap <= 16'h0000;
            r_sel         <= 1'b0;
            r_rdata       <= 16'h0000;
        end else begin
            r_led         <= r_led_next;
            r_scratch     <= r_scratch_next;
            r_cyc         <= r_cyc + 32'd1;
            r_cyc_hi_snap <= r_cyc_hi_snap_next;
            r_sel         <= w_is_mmio;
            r_rdata       <= w_rdata;
        end
    end

    // blram data is already registered, so steering with the registered
    // select keeps both paths at the same one-cycle latency.
    assign cpu_dout = r_sel ? r_rdata : ram_dout;
    assign led      = r_led;

endmodule

// File: tb/tb_tinymips_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_tinymips_bus_responder
// Directed bench for the TinyMIPS bus responder with a behavioural blram.
// The driver issues bus cycles and queues the expected responses with the cycle
// in which they are due; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_tinymips_bus_responder;

    localparam int K_DOUT  = 0;
    localparam int K_LED   = 1;
    localparam int K_IRQ   = 2;
    localparam int K_RAMWE = 3;
    localparam int K_RF2   = 4;

    typedef struct {
        int          kind;
        int          due;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [15:0] led;
    logic        timer_irq;

    logic [15:0] mem [0:255];

    exp_t        sb[$];
    int          tb_cyc = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          rel;
    logic [15:0] rf2;

    logic [15:0] seq_auto [0:7] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                                    16'h0004, 16'h0005, 16'h0000, 16'h0001};
    logic [15:0] seq_wrap [0:5] = '{16'hFFFE, 16'hFFFF, 16'h0000,
                                    16'h0001, 16'h0002, 16'h0003};
    logic [15:0] sum_data [0:4] = '{16'd5, 16'd8, 16'd15, 16'd17, 16'd22};

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // blram: registered read, write-first not required
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    tinymips_bus_responder #(
        .SIZE      (8),
        .MMIO_BASE (8'hF0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .led       (led),
        .timer_irq (timer_irq)
    );

    // ------------------------------------------------------------- monitor
    exp_t        e_cur;
    logic [15:0] act_cur;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= tb_cyc) begin
            e_cur = sb.pop_front();
            case (e_cur.kind)
                K_LED:   act_cur = led;
                K_IRQ:   act_cur = {15'd0, timer_irq};
                K_RAMWE: act_cur = {15'd0, ram_we};
                K_RF2:   act_cur = rf2;
                default: act_cur = cpu_dout;
            endcase
            n_cmp++;
            if (e_cur.due != tb_cyc) begin
                n_bad++;
                $display("FAIL %s: check missed its cycle (due %0d, now %0d)",
                         e_cur.name, e_cur.due, tb_cyc);
            end else if (act_cur !== e_cur.val) begin
                n_bad++;
                $display("FAIL %s: got 0x%04h, expected 0x%04h (cycle %0d)",
                         e_cur.name, act_cur, e_cur.val, tb_cyc);
            end else begin
                $display("ok   %s: 0x%04h (cycle %0d)", e_cur.name, act_cur, tb_cyc);
            end
        end
    end

    // ------------------------------------------------------------- driver
    task automatic push(input int kind, input int delay, input logic [15:0] v,
                        input string nm);
        exp_t e;
        e.kind = kind;
        e.due  = tb_cyc + delay;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic bus(input logic we, input logic [7:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        cpu_we   = we;
        cpu_addr = a;
        cpu_din  = d;
    endtask

    task automatic idle();
        bus(1'b0, 8'h00, 16'h0000);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        bus(1'b1, a, d);
        push(K_RAMWE, 0, (a >= 8'hF0) ? 16'h0000 : 16'h0001,
             $sformatf("ram_we wr[%02h]", a));
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] v, input string nm);
        bus(1'b0, a, 16'h0000);
        push(K_DOUT, 1, v, nm);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 8'h00;
        cpu_din  = 16'h0000;
        rf2      = 16'h0000;
        ram_dout = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // power-on reset
        @(posedge clk);
        #1;
        push(K_DOUT, 0, 16'h0000, "rst dout");
        push(K_LED,  0, 16'h0000, "rst led");
        push(K_IRQ,  0, 16'h0000, "rst irq");
        @(posedge clk);
        #1;
        rst = 1'b1;
        rel = tb_cyc;

        // cycle counter right after release
        rd(8'hF6, 16'h0001, "cyc_lo first");
        rd(8'hF7, 16'h0000, "cyc_hi first");

        // RAM path and LED / SCRATCH
        wr(8'h0A, 16'h1234);
        rd(8'h0A, 16'h1234, "ram[0A]");
        wr(8'hF4, 16'hBEEF);
        push(K_LED, 1, 16'hBEEF, "led pin");
        rd(8'hF4, 16'hBEEF, "led reg");
        wr(8'hF5, 16'hA5A5);
        rd(8'hF5, 16'hA5A5, "scratch");

        // unused offsets: writes ignored, read 0
        wr(8'hF8, 16'hFFFF);
        for (int a = 8'hF8; a <= 8'hFF; a++)
            rd(8'(a), 16'h0000, $sformatf("unused[%02h]", a));

        // coherent LO/HI pair across the 0x0000FFFF -> 0x00010000 carry
        for (int k = 0; k < 70000; k++) begin
            if ((tb_cyc - rel) >= 65534) break;
            idle();
        end
        rd(8'hF6, 16'hFFFF, "cyc_lo @FFFF");
        rd(8'hF7, 16'h0000, "cyc_hi snap");
        rd(8'hF6, 16'h0001, "cyc_lo @10001");
        rd(8'hF7, 16'h0001, "cyc_hi snap2");

        // timer with autoreload: CMP=5, CTRL=EN|AUTORELOAD
        wr(8'hF2, 16'h0005);
        wr(8'hF0, 16'h0003);
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                bus(1'b0, 8'hF1, 16'h0000);
                push(K_IRQ,  0, 16'h0000, "irq before match");
                push(K_DOUT, 1, seq_auto[i], "cnt_auto[5]");
                push(K_IRQ,  1, 16'h0001, "irq after match");
            end else begin
                rd(8'hF1, seq_auto[i], $sformatf("cnt_auto[%0d]", i));
            end
        end
        wr(8'hF0, 16'h0000);
        rd(8'hF3, 16'h0001, "status sticky");
        wr(8'hF3, 16'h0000);
        rd(8'hF3, 16'h0001, "status wr0 keeps");
        wr(8'hF3, 16'h0001);
        rd(8'hF3, 16'h0000, "status wr1 clears");
        push(K_IRQ, 1, 16'h0000, "irq cleared");
        rd(8'hF1, 16'h0003, "cnt held en=0");

        // wrap through 0xFFFF with CMP=3, no autoreload
        wr(8'hF1, 16'hFFFE);
        wr(8'hF2, 16'h0003);
        wr(8'hF0, 16'h0001);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                bus(1'b0, 8'hF1, 16'h0000);
                push(K_IRQ,  0, 16'h0000, "irq before wrap match");
                push(K_DOUT, 1, seq_wrap[i], "cnt_wrap[5]");
                push(K_IRQ,  1, 16'h0001, "irq after wrap match");
            end else begin
                rd(8'hF1, seq_wrap[i], $sformatf("cnt_wrap[%0d]", i));
            end
        end
        rd(8'hF3, 16'h0001, "status wrap match");
        wr(8'hF0, 16'h0000);
        wr(8'hF3, 16'h0001);
        rd(8'hF3, 16'h0000, "status cleared 2");

        // CPU write to CNT beats the increment; disabling still counts once
        wr(8'hF0, 16'h0001);
        wr(8'hF1, 16'h0100);
        rd(8'hF1, 16'h0100, "cnt cpu wins");
        wr(8'hF0, 16'h0000);
        rd(8'hF1, 16'h0102, "cnt old en");

        // clear request in the exact match cycle: set wins
        wr(8'hF2, 16'h0010);
        wr(8'hF1, 16'h000E);
        wr(8'hF0, 16'h0001);
        idle();
        idle();
        wr(8'hF3, 16'h0001);
        rd(8'hF3, 16'h0001, "set beats clear");
        wr(8'hF3, 16'h0001);
        rd(8'hF3, 16'h0000, "clear after match");

        // CTRL readback, force a match, then reset mid-run
        wr(8'hF0, 16'hFFFF);
        rd(8'hF0, 16'h0003, "ctrl readback");
        wr(8'hF1, 16'h0010);
        idle();
        bus(1'b0, 8'hF5, 16'h0000);
        push(K_IRQ, 0, 16'h0001, "irq before reset");
        push(K_LED, 0, 16'hBEEF, "led before reset");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 8'h00;
        push(K_DOUT, 0, 16'h0000, "midrst dout");
        push(K_LED,  0, 16'h0000, "midrst led");
        push(K_IRQ,  0, 16'h0000, "midrst irq");
        @(posedge clk);
        #1;
        rst = 1'b1;
        rel = tb_cyc;
        rd(8'hF6, 16'h0001, "cyc_lo after rst");
        rd(8'hF7, 16'h0000, "cyc_hi after rst");
        rd(8'hF0, 16'h0000, "ctrl after rst");
        rd(8'hF1, 16'h0000, "cnt after rst");
        rd(8'hF2, 16'h0000, "cmp after rst");
        rd(8'hF3, 16'h0000, "status after rst");
        rd(8'hF4, 16'h0000, "led reg after rst");
        rd(8'hF5, 16'h0000, "scratch after rst");
        push(K_IRQ, 1, 16'h0000, "irq after rst");

        // 5-element sum program: data at 10..14, accumulate into RF[2]
        for (int i = 0; i < 5; i++) wr(8'(10 + i), sum_data[i]);
        rf2 = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            rd(8'(10 + i), sum_data[i], $sformatf("lw ram[%0d]", 10 + i));
            @(negedge clk);
            @(negedge clk);
            rf2 = rf2 + cpu_dout;
        end
        idle();
        push(K_RF2, 0, 16'd67, "RF[2] sum");

        idle();
        idle();
        idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tinymips_bus_responder.md
# tinymips_bus_responder

Memory-side responder for the TinyMIPS data/instruction bus, placed between the TinyMIPS core and `blram`. Decodes the 8-bit word address, forwards 0x00–0xEF to the block RAM and serves 0xF0–0xFF from an internal register bank. The bank holds a 16-bit compare timer, an LED register, a scratch word and a 32-bit cycle counter. It keeps the one-cycle read latency the core already expects from `blram`, so the core needs no changes.

## Interface
- `SIZE`, 8: address width in words.
- `MMIO_BASE`, 8'hF0: first register address; the bank spans `MMIO_BASE` to `MMIO_BASE+15`.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-low reset (the block is held in reset while `rst`=0).
- `cpu_we` input 1: write strobe from the core (`wrEn`).
- `cpu_addr` input SIZE: word address from the core.
- `cpu_din` input 16: write data from the core.
- `cpu_dout` output 16: read data to the core, valid one cycle after the address.
- `ram_we` output 1: write strobe to `blram`.
- `ram_addr` output SIZE: address to `blram`.
- `ram_din` output 16: write data to `blram`.
- `ram_dout` input 16: `blram` read data (registered, one-cycle latency).
- `led` output 16: LED register contents.
- `timer_irq` output 1: level copy of `STATUS[0]`.

## Operation
- Decode: `is_mmio = (cpu_addr >= MMIO_BASE)`.
- `ram_addr`/`ram_din` always mirror `cpu_addr`/`cpu_din`.
- `ram_we = cpu_we & ~is_mmio`; RAM is never written by register accesses.
- Register map (offset from `MMIO_BASE`):
  - 0 CTRL, RW: bit0 EN, bit1 AUTORELOAD, other bits read 0.
  - 1 CNT: writable; written value loads the counter.
  - 2 CMP: RW.
  - 3 STATUS: bit0 MATCH, sticky; write 1 clears it.
  - 4 LED: RW, drives `led`.
  - 5 SCRATCH: RW.
  - 6 CYC_LO: read-only.
  - 7 CYC_HI_SNAP: read-only.
  - 8–15: read 0, writes ignored.
- Timer, each cycle with EN=1:
  - If CNT==CMP: set MATCH; next CNT = 0 if AUTORELOAD, else CNT+1.
  - Otherwise CNT+1.
  - All arithmetic is mod 2^16; 0xFFFF wraps to 0x0000.
  - With EN=0, CNT holds.
- Cycle counter: 32-bit, free-running from reset, wraps mod 2^32.
  - A read of CYC_LO latches `cyc[31:16]` into CYC_HI_SNAP in the same cycle, so a LO-then-HI read pair is coherent.
- Conflict priorities:
  - A CPU write to CNT in the same cycle as an increment: the CPU write wins.
  - A STATUS write-1 in the same cycle as a new match: the set wins, MATCH stays 1.
  - A CPU write to CTRL takes effect from the next cycle; the current cycle uses the old EN.

## Timing
- Reset values (asynchronous, while `rst`=0): CTRL, CNT, CMP, STATUS, LED, SCRATCH, cycle counter, CYC_HI_SNAP, the select flop and the read-data register are all 0. As a result `cpu_dout`=0, `led`=0 and `timer_irq`=0 during reset. `ram_*` outputs follow the inputs combinationally.
- Read latency is 1 cycle:
  - The select flop registers `is_mmio`.
  - The data register registers the bank read value.
  - `cpu_dout` = select ? data register : `ram_dout`.
- Register writes commit on the rising edge where `cpu_we`=1. A read of the same address in the next cycle returns the new value.
- `timer_irq` rises in the cycle after the CNT==CMP edge.
- Reset asserted mid-operation clears all state immediately; the first access after release behaves as after power-on.

## Structure
- Package `tinymips_pkg`: register offset constants (OFF_CTRL … OFF_CYC_HI), CTRL bit indices and the `MMIO_BASE` default.
- One sub-module: `mmio_timer`, which holds CTRL/CNT/CMP/STATUS, the increment/match logic and `timer_irq`. Address decode, LED, SCRATCH, the cycle counter and the read mux stay in the top level.

## Test plan
- Write 0x1234 to addr 0x0A, then read 0x0A -> `ram_we` pulses and `cpu_dout`=0x1234 one cycle after the read address. Write 0xBEEF to 0xF4 -> `led`=0xBEEF, `ram_we` stays 0.
- CMP=5, CTRL=3 (EN+AUTORELOAD) -> CNT sequence 0..5,0..; MATCH and `timer_irq` set 1 cycle after CNT==5. Write 1 to STATUS -> cleared; write 0 -> no change.
- CNT=0xFFFE, CMP=0x0003, CTRL=1 -> CNT goes 0xFFFF, 0x0000, …; MATCH sets once CNT reaches 3.
- Write CNT=0x0100 in the same cycle as an increment -> next read 0x0100. STATUS write-1 in the exact match cycle -> MATCH remains 1.
- Read CYC_LO then CYC_HI_SNAP around the 0x0000FFFF→0x00010000 transition -> the pair is consistent. Read 0xF8–0xFF -> 0.
- Pulse `rst`=0 mid-timer-run -> all registers, `led` and `timer_irq` read 0 immediately. Then run the 5-element sum program (data 5, 8, 15, 17, 22 at 10–14) through the responder -> RF[2]=67.
